// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
// Shared constants and types for the shift arbiter slice.
//   DATA_W  : operand / result width (fixed at 32)
//   SHAMT_W : shift amount width (5 bits, covers 0..31)
//   shift_op_e : 1-bit opcode, SLL or SRA; every encoding is legal
// No ports (package).
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

endpackage : shift_arbiter_pkg

// File: rtl/shift_core.sv
// -----------------------------------------------------------------------------
// shift_core
// Purely combinational 32-bit logarithmic barrel shifter (SLL / SRA).
// Five layers shift by 1, 2, 4, 8 and 16, each enabled by one bit of shamt.
// Ports:
//   in_i    [31:0] operand
//   shamt_i [4:0]  shift amount 0..31
//   op_i           0 = SLL, 1 = SRA
//   out_o   [31:0] shifted result
// -----------------------------------------------------------------------------
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  in_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               op_i,
  output logic [DATA_W-1:0]  out_o
);

  // Bit shifted into the vacated positions. For SRA it is the original
  // sign bit; a left shift always brings in zeros from the LSB side.
  logic fillBit;
  assign fillBit = (op_i == OP_SRA) ? in_i[DATA_W-1] : 1'b0;

  // stage[0] is the raw operand, stage[k+1] is the result after layer k.
  logic [DATA_W-1:0] stage [0:SHAMT_W];
  assign stage[0] = in_i;

  // Each layer either passes its input through or shifts it by 2**k,
  // chosen by shamt bit k. Left and right versions are both built and the
  // opcode picks one, so a single instance serves both operations.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
    localparam int S = 1 << k;
    logic [DATA_W-1:0] leftShift;
    logic [DATA_W-1:0] rightShift;

    assign leftShift  = {stage[k][DATA_W-1-S:0], {S{1'b0}}};
    assign rightShift = {{S{fillBit}}, stage[k][DATA_W-1:S]};

    assign stage[k+1] = !shamt_i[k]       ? stage[k]   :
                        (op_i == OP_SRA)  ? rightShift : leftShift;
  end

  assign out_o = stage[SHAMT_W];

endmodule : shift_core

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Shares one combinational barrel shifter between two requesters. A
// round-robin grant picks at most one request per cycle; the shifted value
// is registered and returned on one tagged result channel with backpressure.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (0 or 1)
//   reqN_op                   0 = SLL, 1 = SRA
//   reqN_data  [WIDTH-1:0]    operand
//   reqN_shamt [4:0]          shift amount
//   res_valid / res_ready     result handshake
//   res_data   [WIDTH-1:0]    registered shifted result
//   res_id                    index of the requester that produced res_data
// Parameters:
//   WIDTH     data width, must stay 32 (the shifter is built for 32 bits)
//   FIRST_PRI requester preferred on the first contested cycle after reset
// -----------------------------------------------------------------------------
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int   WIDTH     = 32,
  parameter logic FIRST_PRI = 1'b0
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_op,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_op,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,

  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_id
);

  logic               resValid_q, resValid_d;
  logic [WIDTH-1:0]   resData_q,  resData_d;
  logic               resId_q,    resId_d;
  logic               lastGrant_q, lastGrant_d;

  logic               canLoad;
  logic               anyValid;
  logic               grantIdx;
  logic               accept;
  logic               muxOp;
  logic [WIDTH-1:0]   muxData;
  logic [SHAMT_W-1:0] muxShamt;
  logic [WIDTH-1:0]   shiftOut;

  // The result slot can take a new value when it is empty or when its
  // current value leaves this very cycle, which gives full throughput
  // while the consumer keeps res_ready high.
  assign canLoad  = !resValid_q || res_ready;
  assign anyValid = req0_valid || req1_valid;

  // Round-robin choice: a lone requester always wins; under contention the
  // requester that did not win last time goes next. grantIdx is meaningless
  // when nobody is valid, which is why readys also require anyValid.
  always_comb begin
    grantIdx = 1'b0;
    if (req0_valid && req1_valid) begin
      grantIdx = ~lastGrant_q;
    end else if (req1_valid) begin
      grantIdx = 1'b1;
    end
  end

  // Readys are forced low during reset so that nothing held across reset is
  // accepted before the pointer and result slot are back in a known state.
  assign req0_ready = !reset && canLoad && anyValid && (grantIdx == 1'b0);
  assign req1_ready = !reset && canLoad && anyValid && (grantIdx == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Operand mux feeding the single shifter instance from the granted side.
  always_comb begin
    muxOp    = req0_op;
    muxData  = req0_data;
    muxShamt = req0_shamt;
    if (grantIdx) begin
      muxOp    = req1_op;
      muxData  = req1_data;
      muxShamt = req1_shamt;
    end
  end

  shift_core u_shift_core (
    .in_i    (muxData),
    .shamt_i (muxShamt),
    .op_i    (muxOp),
    .out_o   (shiftOut)
  );

  // Next-state for the result slot and the round-robin pointer. An accept
  // loads a fresh result; a drain with nothing new behind it only clears
  // valid so data and id keep their last value; a stall holds everything.
  always_comb begin
    resValid_d  = resValid_q;
    resData_d   = resData_q;
    resId_d     = resId_q;
    lastGrant_d = lastGrant_q;
    if (accept) begin
      resValid_d  = 1'b1;
      resData_d   = shiftOut;
      resId_d     = grantIdx;
      lastGrant_d = grantIdx;
    end else if (resValid_q && res_ready) begin
      resValid_d  = 1'b0;
    end
  end

  // State registers. The pointer resets to the opposite of FIRST_PRI so that
  // the first contested grant after reset lands on FIRST_PRI.
  always_ff @(posedge clock) begin
    if (reset) begin
      resValid_q  <= 1'b0;
      resData_q   <= '0;
      resId_q     <= 1'b0;
      lastGrant_q <= ~FIRST_PRI;
    end else begin
      resValid_q  <= resValid_d;
      resData_q   <= resData_d;
      resId_q     <= resId_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_id    = resId_q;

endmodule : shift_arbiter

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Directed, self-checking bench for shift_arbiter. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_data;

  int checkCount = 0;
  int passCount  = 0;

  shift_arbiter #(.WIDTH(32), .FIRST_PRI(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0; req1_shamt = '0;
  endtask

  task automatic doReset();
    idleInputs();
    res_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Reset values and readys held low while reset is asserted.
  task automatic test_reset();
    idleInputs();
    res_ready  = 1'b1;
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    checkCount++;
    if (res_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b exp 0", res_valid);
    else passCount++;
    checkCount++;
    if (res_data !== 32'h0) $display("[TB] FAIL reset_data got %h exp 00000000", res_data);
    else passCount++;
    checkCount++;
    if (res_id !== 1'b0) $display("[TB] FAIL reset_id got %b exp 0", res_id);
    else passCount++;
    checkCount++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("[TB] FAIL reset_readys got %b exp 00", {req0_ready, req1_ready});
    else passCount++;
    idleInputs();
    reset = 1'b0;
    #1;
  endtask

  // One SRA from requester 0, one-cycle latency.
  task automatic test_single_sra();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b1; req0_data = 32'h8000_0000; req0_shamt = 5'd4;
    #1;
    checkCount++;
    if (req0_ready !== 1'b1) $display("[TB] FAIL sra_ready got %b exp 1", req0_ready);
    else passCount++;
    tick();
    req0_valid = 1'b0;
    checkCount++;
    if (res_valid !== 1'b1) $display("[TB] FAIL sra_valid got %b exp 1", res_valid);
    else passCount++;
    checkCount++;
    if (res_data !== 32'hF800_0000) $display("[TB] FAIL sra_data got %h exp f8000000", res_data);
    else passCount++;
    checkCount++;
    if (res_id !== 1'b0) $display("[TB] FAIL sra_id got %b exp 0", res_id);
    else passCount++;
    tick();
  endtask

  // Shifter corner cases, alternating the requester used.
  task automatic test_shift_edges();
    logic        opv   [0:6];
    logic [31:0] datav [0:6];
    logic [4:0]  shv   [0:6];
    logic [31:0] expv  [0:6];
    opv[0] = 1'b0; datav[0] = 32'h0000_0001; shv[0] = 5'd31; expv[0] = 32'h8000_0000;
    opv[1] = 1'b1; datav[1] = 32'h7FFF_FFFF; shv[1] = 5'd31; expv[1] = 32'h0000_0000;
    opv[2] = 1'b1; datav[2] = 32'hDEAD_BEEF; shv[2] = 5'd0;  expv[2] = 32'hDEAD_BEEF;
    opv[3] = 1'b0; datav[3] = 32'h1234_5678; shv[3] = 5'd4;  expv[3] = 32'h2345_6780;
    opv[4] = 1'b1; datav[4] = 32'h8000_0000; shv[4] = 5'd31; expv[4] = 32'hFFFF_FFFF;
    opv[5] = 1'b1; datav[5] = 32'hF000_0000; shv[5] = 5'd16; expv[5] = 32'hFFFF_F000;
    opv[6] = 1'b0; datav[6] = 32'hFFFF_FFFF; shv[6] = 5'd16; expv[6] = 32'hFFFF_0000;
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        req0_valid = 1'b1; req0_op = opv[i]; req0_data = datav[i]; req0_shamt = shv[i];
      end else begin
        req1_valid = 1'b1; req1_op = opv[i]; req1_data = datav[i]; req1_shamt = shv[i];
      end
      tick();
      idleInputs();
      checkCount++;
      if (res_data !== expv[i])
        $display("[TB] FAIL edge%0d_data got %h exp %h", i, res_data, expv[i]);
      else passCount++;
      checkCount++;
      if (res_id !== (i % 2 == 1))
        $display("[TB] FAIL edge%0d_id got %b exp %0d", i, res_id, i % 2);
      else passCount++;
    end
    tick();
  endtask

  // Both requesters valid for four cycles straight after reset.
  task automatic test_contention();
    logic expId;
    doReset();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_0011; req0_shamt = 5'd0;
    req1_valid = 1'b1; req1_op = 1'b0; req1_data = 32'h0000_0022; req1_shamt = 5'd1;
    for (int i = 0; i < 4; i++) begin
      expId = (i % 2 == 1);
      #1;
      checkCount++;
      if ({req1_ready, req0_ready} !== (expId ? 2'b10 : 2'b01))
        $display("[TB] FAIL cont%0d_readys got r1r0=%b exp grant %0d", i,
                 {req1_ready, req0_ready}, expId);
      else passCount++;
      tick();
      checkCount++;
      if (res_id !== expId) $display("[TB] FAIL cont%0d_id got %b exp %b", i, res_id, expId);
      else passCount++;
      checkCount++;
      if (res_data !== (expId ? 32'h0000_0044 : 32'h0000_0011))
        $display("[TB] FAIL cont%0d_data got %h exp %h", i, res_data,
                 expId ? 32'h0000_0044 : 32'h0000_0011);
      else passCount++;
    end
    idleInputs();
    tick();
  endtask

  // Stalled result must hold; release lets the next accept happen at once.
  task automatic test_backpressure();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_0003; req0_shamt = 5'd1;
    tick();
    res_ready  = 1'b0;
    req0_data  = 32'h0000_0007;
    req1_valid = 1'b1; req1_op = 1'b0; req1_data = 32'h0000_0005; req1_shamt = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCount++;
      if ({req0_ready, req1_ready} !== 2'b00)
        $display("[TB] FAIL bp%0d_readys got %b exp 00", i, {req0_ready, req1_ready});
      else passCount++;
      tick();
      checkCount++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 32'h0000_0006})
        $display("[TB] FAIL bp%0d_hold got v=%b id=%b d=%h exp v=1 id=0 d=00000006", i,
                 res_valid, res_id, res_data);
      else passCount++;
    end
    res_ready = 1'b1;
    #1;
    checkCount++;
    if (req1_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b exp 1", req1_ready);
    else passCount++;
    tick();
    req1_valid = 1'b0;
    checkCount++;
    if ({res_id, res_data} !== {1'b1, 32'h0000_0014})
      $display("[TB] FAIL bp_release_result got id=%b d=%h exp id=1 d=00000014", res_id, res_data);
    else passCount++;
    tick();
    idleInputs();
    tick();
  endtask

  // Single result then idle: valid drops, data and id hold.
  task automatic test_drain();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_00A5; req0_shamt = 5'd8;
    tick();
    idleInputs();
    checkCount++;
    if ({res_valid, res_data} !== {1'b1, 32'h0000_A500})
      $display("[TB] FAIL drain_load got v=%b d=%h exp v=1 d=0000a500", res_valid, res_data);
    else passCount++;
    tick();
    checkCount++;
    if ({res_valid, res_id, res_data} !== {1'b0, 1'b0, 32'h0000_A500})
      $display("[TB] FAIL drain_idle got v=%b id=%b d=%h exp v=0 id=0 d=0000a500",
               res_valid, res_id, res_data);
    else passCount++;
    tick();
  endtask

  // Reset during a stall discards the result and restores the pointer.
  task automatic test_reset_mid_stall();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b1; req0_data = 32'h0000_00F0; req0_shamt = 5'd4;
    tick();
    res_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_0100; req0_shamt = 5'd1;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 32'h0000_0100; req1_shamt = 5'd8;
    tick();
    checkCount++;
    if ({res_valid, res_data} !== {1'b1, 32'h0000_000F})
      $display("[TB] FAIL rst_stall_pending got v=%b d=%h exp v=1 d=0000000f", res_valid, res_data);
    else passCount++;
    reset = 1'b1;
    tick();
    checkCount++;
    if ({res_valid, res_data} !== {1'b0, 32'h0})
      $display("[TB] FAIL rst_stall_cleared got v=%b d=%h exp v=0 d=00000000", res_valid, res_data);
    else passCount++;
    checkCount++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("[TB] FAIL rst_stall_readys got %b exp 00", {req0_ready, req1_ready});
    else passCount++;
    reset = 1'b0;
    #1;
    checkCount++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("[TB] FAIL rst_regrant_first got r1r0=%b exp 01", {req1_ready, req0_ready});
    else passCount++;
    res_ready = 1'b1;
    tick();
    checkCount++;
    if ({res_id, res_data} !== {1'b0, 32'h0000_0200})
      $display("[TB] FAIL rst_regrant0 got id=%b d=%h exp id=0 d=00000200", res_id, res_data);
    else passCount++;
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    checkCount++;
    if ({res_id, res_data} !== {1'b1, 32'h0000_0001})
      $display("[TB] FAIL rst_regrant1 got id=%b d=%h exp id=1 d=00000001", res_id, res_data);
    else passCount++;
    tick();
  endtask

  // Scenario sequence and summary.
  initial begin
    idleInputs();
    reset     = 1'b1;
    res_ready = 1'b1;
    test_reset();
    test_single_sra();
    test_shift_edges();
    test_contention();
    test_backpressure();
    test_drain();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_shift_arbiter
